// File: rtl/dmem_sync.sv
// Clocked data memory with byte enables, programmable wait states and address error flagging.
module dmem_sync #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 256,
  parameter int WAIT_CYC  = 0,
  parameter     INIT_FILE = "dmem.hex"
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Ewr,
  input  logic                Erd,
  input  logic [31:0]         Addr,
  input  logic [DATA_W-1:0]   RDir,
  input  logic [DATA_W/8-1:0] BEn,
  output logic [DATA_W-1:0]   MOut,
  output logic                Ready,
  output logic                Busy,
  output logic                AddrErr
);

  // state  | meaning
  // IDLE   | waiting for a request; inputs sampled here only
  // WAIT   | counting down extra wait cycles
  // DONE   | array update and result capture on the next edge
  localparam int AW = $clog2(DEPTH);
  localparam int NB = DATA_W / 8;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic [AW-1:0]     idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [NB-1:0]     ben_q;
  logic              wr_q;
  logic              rd_q;
  logic              err_q;
  logic              accept;
  logic              addr_bad;
  logic [DATA_W-1:0] merged;

  assign accept   = (state == S_IDLE) && (Ewr || Erd);
  assign addr_bad = (Addr[1:0] != 2'b00) || (Addr[31:AW+2] != '0);

  // Post-write view of the addressed word; also the read result for Ewr+Erd.
  always_comb begin
    merged = mem[idx_q];
    for (int i = 0; i < NB; i++) begin
      if (wr_q && ben_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      ben_q   <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
      MOut    <= '0;
      Ready   <= 1'b0;
      Busy    <= 1'b0;
      AddrErr <= 1'b0;
    end else begin
      Ready <= (state == S_DONE);
      if (accept)     Busy <= 1'b1;
      else if (Ready) Busy <= 1'b0;

      case (state)
        S_IDLE: begin
          if (accept) begin
            idx_q   <= Addr[AW+1:2];
            wdata_q <= RDir;
            ben_q   <= BEn;
            wr_q    <= Ewr;
            rd_q    <= Erd;
            err_q   <= addr_bad;
            if (WAIT_CYC == 0) begin
              state <= S_DONE;
            end else begin
              state <= S_WAIT;
              cnt   <= 4'(WAIT_CYC - 1);
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) state <= S_DONE;
          else             cnt   <= cnt - 4'd1;
        end
        S_DONE: begin
          state   <= S_IDLE;
          AddrErr <= err_q;
          if (err_q)     MOut <= '0;
          else if (rd_q) MOut <= merged;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst && (state == S_DONE) && wr_q && !err_q) mem[idx_q] <= merged;
  end

endmodule

// File: tb/tb_dmem_sync.sv
// Randomized bench for dmem_sync: one instance without wait states, one with three,
// both compared against a word-array reference model.
module tb_dmem_sync;

  logic        clk;
  logic        rst  [2];
  logic        ewr  [2];
  logic        erd  [2];
  logic [31:0] addr [2];
  logic [31:0] rdir [2];
  logic [3:0]  ben  [2];
  logic [31:0] mout [2];
  logic        ready[2];
  logic        busy [2];
  logic        aerr [2];

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] ref_mem [2][256];
  logic [31:0] ref_mout[2];
  bit          mout_known[2];

  dmem_sync #(.DATA_W(32), .DEPTH(256), .WAIT_CYC(0)) u_dut0 (
    .Clk(clk), .Rst(rst[0]), .Ewr(ewr[0]), .Erd(erd[0]), .Addr(addr[0]),
    .RDir(rdir[0]), .BEn(ben[0]), .MOut(mout[0]), .Ready(ready[0]),
    .Busy(busy[0]), .AddrErr(aerr[0])
  );

  dmem_sync #(.DATA_W(32), .DEPTH(256), .WAIT_CYC(3)) u_dut1 (
    .Clk(clk), .Rst(rst[1]), .Ewr(ewr[1]), .Erd(erd[1]), .Addr(addr[1]),
    .RDir(rdir[1]), .BEn(ben[1]), .MOut(mout[1]), .Ready(ready[1]),
    .Busy(busy[1]), .AddrErr(aerr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic access(input int d, input bit wr, input bit rd, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be, input bit junk);
    int          lat;
    int          w;
    bit          got;
    bit          err;
    logic [31:0] word;
    w = wait_of(d);
    @(negedge clk);
    ewr[d] = wr; erd[d] = rd; addr[d] = a; rdir[d] = wd; ben[d] = be;
    @(posedge clk); #1;
    ewr[d] = 1'b0; erd[d] = 1'b0;
    check("busy_after_accept", 32'(busy[d]), 32'd1);
    lat = 0;
    got = 1'b0;
    while (lat < 40 && !got) begin
      @(posedge clk); #1;
      lat++;
      if (ready[d]) begin
        got = 1'b1;
      end else begin
        check("busy_while_pending", 32'(busy[d]), 32'd1);
        if (junk && lat < w) begin
          ewr[d]  = 1'($urandom_range(0, 1));
          erd[d]  = 1'($urandom_range(0, 1));
          addr[d] = $urandom_range(0, 255) * 4;
          rdir[d] = $urandom;
          ben[d]  = 4'($urandom_range(0, 15));
        end else begin
          ewr[d] = 1'b0; erd[d] = 1'b0;
        end
      end
    end
    check("ready_seen", 32'(got), 32'd1);
    check("latency", 32'(lat), 32'(w + 1));

    err = (a[1:0] != 2'b00) || (a[31:10] != 22'd0);
    if (!err) begin
      word = ref_mem[d][a[9:2]];
      if (wr) begin
        for (int i = 0; i < 4; i++) if (be[i]) word[8*i +: 8] = wd[8*i +: 8];
        ref_mem[d][a[9:2]] = word;
      end
      if (rd) begin
        ref_mout[d]   = word;
        mout_known[d] = 1'b1;
      end
    end else begin
      ref_mout[d]   = 32'd0;
      mout_known[d] = rd;
    end

    if (got) begin
      check("busy_with_ready", 32'(busy[d]), 32'd1);
      check("addr_err", 32'(aerr[d]), 32'(err));
      if (mout_known[d]) check("mout", mout[d], ref_mout[d]);
      @(posedge clk); #1;
      check("ready_one_cycle", 32'(ready[d]), 32'd0);
      check("busy_fall", 32'(busy[d]), 32'd0);
    end
  endtask

  task automatic rand_access(input int d);
    int          r;
    logic [31:0] a;
    bit          wr;
    bit          rd;
    r = $urandom_range(0, 9);
    a = $urandom_range(0, 255) * 4;
    if (r == 0) a = a | 32'($urandom_range(1, 3));
    if (r == 1) a = a | (32'($urandom_range(1, 4194303)) << 10);
    r  = $urandom_range(0, 2);
    wr = (r != 1);
    rd = (r != 0);
    access(d, wr, rd, a, $urandom, 4'($urandom_range(0, 15)), d == 1);
  endtask

  initial begin
    logic [31:0] old8;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; ewr[d] = 1'b0; erd[d] = 1'b0;
      addr[d] = '0; rdir[d] = '0; ben[d] = '0;
      ref_mout[d] = 32'd0; mout_known[d] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      for (int d = 0; d < 2; d++) begin
        check("rst_mout", mout[d], 32'd0);
        check("rst_ready", 32'(ready[d]), 32'd0);
        check("rst_busy", 32'(busy[d]), 32'd0);
        check("rst_aerr", 32'(aerr[d]), 32'd0);
      end
      @(posedge clk); #1;
    end

    // Give every word a defined value before any read.
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 256; i++)
        access(d, 1'b1, 1'b0, 32'(i * 4), $urandom, 4'hF, 1'b0);

    access(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
    access(0, 1'b0, 1'b1, 32'h10, 32'h0, 4'h0, 1'b0);
    check("deadbeef_lit", mout[0], 32'hDEADBEEF);
    access(0, 1'b1, 1'b0, 32'h20, 32'h11223344, 4'hF, 1'b0);
    access(0, 1'b1, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0);
    check("collide_lit", mout[0], 32'h11BB33DD);
    access(0, 1'b1, 1'b0, 32'h24, 32'h01020304, 4'h0, 1'b0);
    check("wr_only_hold", mout[0], 32'h11BB33DD);
    access(0, 1'b0, 1'b1, 32'h402, 32'h0, 4'h0, 1'b0);
    check("err_read_lit", mout[0], 32'h0);
    access(0, 1'b1, 1'b0, 32'h400, 32'hFFFFFFFF, 4'hF, 1'b0);
    access(0, 1'b0, 1'b1, 32'h000, 32'h0, 4'h0, 1'b0);

    access(1, 1'b0, 1'b1, 32'h20, 32'h0, 4'h0, 1'b1);
    access(1, 1'b1, 1'b1, 32'h30, 32'hCAFEF00D, 4'b1010, 1'b1);

    // Abort a pending write by reset during the second wait cycle.
    old8 = ref_mem[1][2];
    @(negedge clk);
    ewr[1] = 1'b1; addr[1] = 32'h8; rdir[1] = 32'h5A5A5A5A; ben[1] = 4'hF;
    @(posedge clk); #1;
    ewr[1] = 1'b0;
    @(posedge clk); #1;
    rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      check("abort_no_ready", 32'(ready[1]), 32'd0);
      @(posedge clk); #1;
    end
    check("abort_busy", 32'(busy[1]), 32'd0);
    check("abort_mout", mout[1], 32'd0);
    check("abort_aerr", 32'(aerr[1]), 32'd0);
    ref_mout[1] = 32'd0; mout_known[1] = 1'b1;
    access(1, 1'b0, 1'b1, 32'h8, 32'h0, 4'h0, 1'b0);
    check("abort_old_word", mout[1], old8);

    for (int n = 0; n < 150; n++) begin
      rand_access(0);
      rand_access(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
